// File: rtl/aes_iterative_core.sv
// Iterative AES encryption core: one round per clock with the round key
// expanded on the fly from the latched cipher key (AES-128 or AES-256).
// Valid/ready handshakes on both sides; one block in flight at a time.
module aes_iterative_core #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                busy
);

  localparam int NR = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Byte b sits at bit offset 8*(255-b); {~b,3'b111} is its top bit.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    for (int i = 0; i < 16; i++) begin
      sub_bytes[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
  endfunction

  // Row r of column c takes the byte from column (c+r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    mix_column[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    mix_column[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    mix_column[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    for (int c = 0; c < 4; c++) begin
      mix_columns[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
  endfunction

  // Four-word expansion: each new word is the previous new word XOR the
  // word four positions back; the chain starts from the transformed word t.
  function automatic logic [127:0] expand_step(input logic [127:0] prev, input logic [31:0] t);
    logic [31:0] n0, n1, n2, n3;
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    expand_step = {n0, n1, n2, n3};
  endfunction

  state_t              state_r, state_nxt;
  logic [3:0]          round_r, round_nxt;
  logic [127:0]        st_r, st_nxt;
  logic [KEY_BITS-1:0] key_r, key_nxt;
  logic [7:0]          rcon_r, rcon_nxt;
  logic [127:0]        data_out_r, data_out_nxt;
  logic                out_valid_r, out_valid_nxt;
  logic                in_ready_r, in_ready_nxt;
  logic                busy_r, busy_nxt;

  logic [127:0]        rk_cur_s;
  logic [KEY_BITS-1:0] key_sched_s;
  logic                rcon_adv_s;
  logic [127:0]        round_out_s;

  if (KEY_BITS == 128) begin : g_k128
    // key_r holds rk[round-1]; derive rk[round] and carry it forward.
    always_comb begin
      rk_cur_s    = expand_step(key_r, sub_word(rot_word(key_r[31:0])) ^ {rcon_r, 24'h000000});
      key_sched_s = rk_cur_s;
      rcon_adv_s  = 1'b1;
    end
  end else if (KEY_BITS == 256) begin : g_k256
    logic [31:0] t_s;
    // key_r = {rk[round-1], rk[round]}; compute rk[round+1] and slide the window.
    // Odd rounds produce an even-indexed key (RotWord+SubWord+Rcon).
    always_comb begin
      if (round_r[0]) begin
        t_s = sub_word(rot_word(key_r[31:0])) ^ {rcon_r, 24'h000000};
      end else begin
        t_s = sub_word(key_r[31:0]);
      end
      rk_cur_s    = key_r[127:0];
      key_sched_s = {key_r[127:0], expand_step(key_r[255:128], t_s)};
      rcon_adv_s  = round_r[0];
    end
  end else begin : g_bad_key_bits
    $error("aes_iterative_core: KEY_BITS must be 128 or 256");
  end

  // One cipher round; the last round skips MixColumns.
  always_comb begin
    if (round_r == LAST_ROUND) begin
      round_out_s = shift_rows(sub_bytes(st_r)) ^ rk_cur_s;
    end else begin
      round_out_s = mix_columns(shift_rows(sub_bytes(st_r))) ^ rk_cur_s;
    end
  end

  // Next-state and next-register logic for the IDLE/ROUND/DONE controller.
  always_comb begin
    state_nxt     = state_r;
    round_nxt     = round_r;
    st_nxt        = st_r;
    key_nxt       = key_r;
    rcon_nxt      = rcon_r;
    data_out_nxt  = data_out_r;
    out_valid_nxt = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          key_nxt   = key;
          st_nxt    = data_in ^ key[KEY_BITS-1 -: 128];
          rcon_nxt  = 8'h01;
          round_nxt = 4'd1;
          state_nxt = ROUND;
        end else begin
          state_nxt = IDLE;
        end
      end
      ROUND: begin
        st_nxt   = round_out_s;
        key_nxt  = key_sched_s;
        rcon_nxt = rcon_adv_s ? xtime(rcon_r) : rcon_r;
        if (round_r == LAST_ROUND) begin
          data_out_nxt  = round_out_s;
          out_valid_nxt = 1'b1;
          round_nxt     = 4'd0;
          state_nxt     = DONE;
        end else begin
          round_nxt = round_r + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          out_valid_nxt = 1'b1;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        round_nxt     = 4'd0;
        state_nxt     = IDLE;
      end
    endcase
    in_ready_nxt = (state_nxt == IDLE);
    busy_nxt     = (state_nxt == ROUND);
  end

  // State and datapath registers; reset discards any in-flight block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      round_r     <= 4'd0;
      st_r        <= 128'h0;
      key_r       <= '0;
      rcon_r      <= 8'h00;
      data_out_r  <= 128'h0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      round_r     <= round_nxt;
      st_r        <= st_nxt;
      key_r       <= key_nxt;
      rcon_r      <= rcon_nxt;
      data_out_r  <= data_out_nxt;
      out_valid_r <= out_valid_nxt;
      in_ready_r  <= in_ready_nxt;
      busy_r      <= busy_nxt;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_aes_iterative_core.sv
// Bench for aes_iterative_core: an AES-128 and an AES-256 instance side by
// side, a transaction-level reference model compared every cycle, plus
// directed FIPS-197 vectors with literal expected ciphertexts.
module tb_aes_iterative_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid_a  [2];
  logic         in_ready_a  [2];
  logic [127:0] din_a       [2];
  logic [255:0] key_a       [2];
  logic         out_valid_a [2];
  logic         out_ready_a [2];
  logic [127:0] dout_a      [2];
  logic         busy_a      [2];

  aes_iterative_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .data_in(din_a[0]), .key(key_a[0][255:128]), .out_valid(out_valid_a[0]),
    .out_ready(out_ready_a[0]), .data_out(dout_a[0]), .busy(busy_a[0])
  );

  aes_iterative_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .data_in(din_a[1]), .key(key_a[1]), .out_valid(out_valid_a[1]),
    .out_ready(out_ready_a[1]), .data_out(dout_a[1]), .busy(busy_a[1])
  );

  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", name, d, act, exp);
    end
  endtask

  // ---------------- reference AES, straight from the cipher definition ----
  logic [7:0] sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box as multiplicative inverse followed by the affine transform.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, r;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  s [16];
    logic [7:0]  u [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) u[j] = sbt[s[j]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = u[q+4*((c+q)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // ---------------- cycle-level transaction model ----------------
  // phase 0 = waiting for a block, 1 = computing, 2 = holding a result
  int           m_ph  [2];
  int           m_cnt [2];
  logic         m_ov  [2];
  logic [127:0] m_do  [2];
  logic [127:0] m_exp [2];

  // Model update on each clock edge; reset clears everything asynchronously.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_ph[d]  <= 0;
        m_cnt[d] <= 0;
        m_ov[d]  <= 1'b0;
        m_do[d]  <= 128'h0;
        m_exp[d] <= 128'h0;
      end else if (m_ph[d] == 0) begin
        if (in_valid_a[d] === 1'b1) begin
          m_exp[d] <= aes_ref(key_a[d], (d == 1) ? 8 : 4, din_a[d]);
          m_cnt[d] <= 0;
          m_ph[d]  <= 1;
        end
      end else if (m_ph[d] == 1) begin
        if (m_cnt[d] == ((d == 1) ? 13 : 9)) begin
          m_ph[d] <= 2;
          m_ov[d] <= 1'b1;
          m_do[d] <= m_exp[d];
        end else begin
          m_cnt[d] <= m_cnt[d] + 1;
        end
      end else begin
        if (out_ready_a[d] === 1'b1) begin
          m_ov[d] <= 1'b0;
          m_ph[d] <= 0;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("cyc_in_ready", d, {127'h0, in_ready_a[d]}, {127'h0, m_ph[d] == 0});
        chk("cyc_busy", d, {127'h0, busy_a[d]}, {127'h0, m_ph[d] == 1});
        chk("cyc_out_valid", d, {127'h0, out_valid_a[d]}, {127'h0, m_ov[d]});
        chk("cyc_data_out", d, dout_a[d], m_do[d]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ov(input int d, output int n);
    n = 0;
    while (out_valid_a[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handshake(input int d, input string name);
    out_ready_a[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[d] = 1'b0;
    chk({name, "_ov_clear"}, d, {127'h0, out_valid_a[d]}, 128'h0);
    chk({name, "_ready_back"}, d, {127'h0, in_ready_a[d]}, 128'h1);
  endtask

  task automatic run_one(input int d, input logic [255:0] k, input logic [127:0] pt,
                         input logic [127:0] ct, input string name);
    int lat, bcnt;
    @(posedge clk); #1;
    key_a[d] = k; din_a[d] = pt; in_valid_a[d] = 1'b1; out_ready_a[d] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    lat = 0;
    bcnt = (busy_a[d] === 1'b1) ? 1 : 0;
    while (out_valid_a[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_a[d] === 1'b1) bcnt++;
    end
    chk({name, "_latency"}, d, 128'(lat), 128'((d == 1) ? 14 : 10));
    chk({name, "_busy_cycles"}, d, 128'(bcnt), 128'((d == 1) ? 14 : 10));
    chk({name, "_ct"}, d, dout_a[d], ct);
    handshake(d, name);
  endtask

  logic [255:0] bk [4];
  logic [127:0] bp [4];
  logic [127:0] bc [4];

  initial begin
    int n, prev;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b0; out_ready_a[d] = 1'b0; din_a[d] = 128'h0; key_a[d] = 256'h0;
    end
    for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));

    // pin the reference model to published vectors
    chk("model_B", 0, aes_ref(KEY_B, 4, PT_B), CT_B);
    chk("model_C1", 0, aes_ref(KEY_C1, 4, PT_C), CT_C1);
    chk("model_C3", 1, aes_ref(KEY_C3, 8, PT_C), CT_C3);

    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", d, {127'h0, in_ready_a[d]}, 128'h1);
      chk("rst_out_valid", d, {127'h0, out_valid_a[d]}, 128'h0);
      chk("rst_data_out", d, dout_a[d], 128'h0);
      chk("rst_busy", d, {127'h0, busy_a[d]}, 128'h0);
    end

    run_one(0, KEY_B, PT_B, CT_B, "vecB");
    run_one(0, KEY_C1, PT_C, CT_C1, "vecC1");
    run_one(1, KEY_C3, PT_C, CT_C3, "vecC3");

    // backpressure with a second block offered while the result is held
    @(posedge clk); #1;
    key_a[0] = KEY_B; din_a[0] = PT_B; in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    wait_ov(0, n);
    chk("bp_latency", 0, 128'(n), 128'd10);
    key_a[0] = KEY_C1; din_a[0] = PT_C; in_valid_a[0] = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 0, dout_a[0], CT_B);
      chk("bp_hold_valid", 0, {127'h0, out_valid_a[0]}, 128'h1);
      chk("bp_in_ready_low", 0, {127'h0, in_ready_a[0]}, 128'h0);
    end
    handshake(0, "bp");
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    chk("bp_second_accepted", 0, {127'h0, busy_a[0]}, 128'h1);
    wait_ov(0, n);
    chk("bp_second_ct", 0, dout_a[0], CT_C1);
    handshake(0, "bp2");

    // inputs disturbed during ROUND must not affect the result
    @(posedge clk); #1;
    key_a[0] = KEY_C1; din_a[0] = PT_C; in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0; key_a[0] = ~KEY_C1; din_a[0] = ~PT_C;
    @(posedge clk); #1;
    key_a[0] = KEY_B; din_a[0] = PT_B;
    wait_ov(0, n);
    chk("disturb_ct", 0, dout_a[0], CT_C1);
    handshake(0, "disturb");

    // reset in the middle of round 5
    @(posedge clk); #1;
    key_a[0] = KEY_B; din_a[0] = PT_B; in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 0, {127'h0, out_valid_a[0]}, 128'h0);
    chk("midrst_data_out", 0, dout_a[0], 128'h0);
    chk("midrst_in_ready", 0, {127'h0, in_ready_a[0]}, 128'h1);
    chk("midrst_busy", 0, {127'h0, busy_a[0]}, 128'h0);
    run_one(0, KEY_B, PT_B, CT_B, "after_rst");

    // back-to-back blocks with in_valid and out_ready tied high
    bk[0] = KEY_B;  bp[0] = PT_B; bc[0] = CT_B;
    bk[1] = KEY_C1; bp[1] = PT_C; bc[1] = CT_C1;
    bk[2] = KEY_B;  bp[2] = PT_B; bc[2] = CT_B;
    bk[3] = KEY_C1; bp[3] = PT_C; bc[3] = CT_C1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b1; key_a[0] = bk[0]; din_a[0] = bp[0]; in_valid_a[0] = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ov(0, n);
      chk("b2b_ct", 0, dout_a[0], bc[k]);
      if (k > 0) chk("b2b_spacing", 0, 128'(cyc - prev), 128'd12);
      prev = cyc;
      if (k < 3) begin
        key_a[0] = bk[k+1]; din_a[0] = bp[k+1];
      end else begin
        in_valid_a[0] = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
